// File: rtl/qsys1_pio_ex_pkg.sv
// Shared constants for the qsys1_pio_ex parallel I/O block.
// Holds the register offsets of the slave port and the EDGE_TYPE encodings.
// Imported by the top level and the edge-detector sub-module.
package qsys1_pio_ex_pkg;

    typedef logic [2:0] addr_t;

    // Register map offsets; 6 and 7 are reserved.
    localparam addr_t ADDR_DATA     = 3'd0;
    localparam addr_t ADDR_DIR      = 3'd1;
    localparam addr_t ADDR_IRQMASK  = 3'd2;
    localparam addr_t ADDR_EDGECAP  = 3'd3;
    localparam addr_t ADDR_OUTSET   = 3'd4;
    localparam addr_t ADDR_OUTCLEAR = 3'd5;

    // EDGE_TYPE encodings.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/qsys1_pio_ex_edge.sv
// Input synchronizer plus per-bit edge detector for the PIO pins.
// Ports: clk/reset; in_port (async pins); in_sync (2-flop synchronized pins);
//        edge_det (one-cycle pulse per bit for the selected edge type).
module qsys1_pio_ex_edge
    import qsys1_pio_ex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edges;
    // Low for the first cycle after reset so the stage flush cannot
    // masquerade as a pin transition.
    logic             armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            in_prev   <= '0;
            armed     <= 1'b0;
        end else begin
            sync_meta <= in_port;
            sync_q    <= sync_meta;
            in_prev   <= sync_q;
            armed     <= 1'b1;
        end
    end

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_FALLING: edges = ~sync_q & in_prev;
            EDGE_ANY:     edges = sync_q ^ in_prev;
            default:      edges = sync_q & ~in_prev;
        endcase
    end

    assign in_sync  = sync_q;
    assign edge_det = armed ? edges : '0;

endmodule

// File: rtl/qsys1_pio_ex.sv
// Memory-mapped parallel I/O port with edge capture and a level interrupt.
// Ports: clk/reset; slave bus (address, chipselect, write_n, read_n,
//        writedata, readdata); pins (in_port, out_port, oe); irq.
module qsys1_pio_ex
    import qsys1_pio_ex_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] ec_clear;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             irq_nxt;
    // Upper writedata bits are intentionally ignored for narrow ports.
    logic             unused_wd;

    assign unused_wd = ^writedata;

    qsys1_pio_ex_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    always_comb begin
        wr_en    = chipselect & ~write_n;
        rd_en    = chipselect & ~read_n;
        wd       = writedata[WIDTH-1:0];
        ec_clear = (wr_en && address == ADDR_EDGECAP) ? wd : '0;
        irq_nxt  = (IRQ_EN != 0) ? |(edgecapture & irqmask) : 1'b0;
    end

    // Read mux: outset/outclear and reserved offsets return zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = (in_sync & ~direction) | (data_out & direction);
            ADDR_DIR:     rd_mux[WIDTH-1:0] = direction;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= RESET_VALUE;
            direction   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_DATA:     data_out  <= wd;
                    ADDR_DIR:      direction <= wd;
                    ADDR_IRQMASK:  irqmask   <= (IRQ_EN != 0) ? wd : '0;
                    ADDR_OUTSET:   data_out  <= data_out | wd;
                    ADDR_OUTCLEAR: data_out  <= data_out & ~wd;
                    default:       ;
                endcase
            end
            // New edges are ORed in after the clear so a coincident edge wins.
            edgecapture <= (edgecapture & ~ec_clear) | edge_det;
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq <= irq_nxt;
        end
    end

    assign out_port = data_out;
    assign oe       = direction;

endmodule

// File: tb/tb_qsys1_pio_ex.sv
module tb_qsys1_pio_ex;

    logic clk;
    logic reset;

    // DUT A: 32-bit, rising edge, non-zero reset value.
    logic [2:0]  a_addr;
    logic        a_cs, a_wn, a_rn;
    logic [31:0] a_wd, a_rd;
    logic [31:0] a_in, a_out, a_oe;
    logic        a_irq;

    // DUT B: 8-bit port.
    logic [2:0]  b_addr;
    logic        b_cs, b_wn, b_rn;
    logic [31:0] b_wd, b_rd;
    logic [7:0]  b_in, b_out, b_oe;
    logic        b_irq;

    int vectors;
    int miscompares;

    logic [31:0] qa_exp[$];
    string       qa_name[$];
    logic [31:0] qb_exp[$];
    string       qb_name[$];

    qsys1_pio_ex #(
        .WIDTH(32), .RESET_VALUE(32'hDEAD_BEEF), .EDGE_TYPE(0), .IRQ_EN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .address(a_addr), .chipselect(a_cs),
        .write_n(a_wn), .read_n(a_rn), .writedata(a_wd), .readdata(a_rd),
        .in_port(a_in), .out_port(a_out), .oe(a_oe), .irq(a_irq)
    );

    qsys1_pio_ex #(
        .WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_TYPE(0), .IRQ_EN(1)
    ) dut_b (
        .clk(clk), .reset(reset), .address(b_addr), .chipselect(b_cs),
        .write_n(b_wn), .read_n(b_rn), .writedata(b_wd), .readdata(b_rd),
        .in_port(b_in), .out_port(b_out), .oe(b_oe), .irq(b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input int sel, input logic [2:0] ad, input logic [31:0] d);
        if (sel == 0) begin
            a_addr = ad; a_wd = d; a_cs = 1'b1; a_wn = 1'b0;
        end else begin
            b_addr = ad; b_wd = d; b_cs = 1'b1; b_wn = 1'b0;
        end
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; b_cs = 1'b0; b_wn = 1'b1;
    endtask

    task automatic bus_rd(input int sel, input logic [2:0] ad, input logic [31:0] exp, input string name);
        if (sel == 0) begin
            qa_exp.push_back(exp); qa_name.push_back(name);
            a_addr = ad; a_cs = 1'b1; a_rn = 1'b0;
        end else begin
            qb_exp.push_back(exp); qb_name.push_back(name);
            b_addr = ad; b_cs = 1'b1; b_rn = 1'b0;
        end
        @(negedge clk);
        a_cs = 1'b0; a_rn = 1'b1; b_cs = 1'b0; b_rn = 1'b1;
    endtask

    // Monitor: a read sampled on a rising edge has its data on readdata
    // from that edge on; compare at the following falling edge.
    initial begin
        logic fa, fb;
        forever begin
            @(posedge clk);
            fa = a_cs && !a_rn && !reset;
            fb = b_cs && !b_rn && !reset;
            @(negedge clk);
            if (fa) begin
                if (qa_exp.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL a_unexpected_read: got 0x%08h expected no read", a_rd);
                end else begin
                    check(qa_name.pop_front(), a_rd, qa_exp.pop_front());
                end
            end
            if (fb) begin
                if (qb_exp.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b_unexpected_read: got 0x%08h expected no read", b_rd);
                end else begin
                    check(qb_name.pop_front(), b_rd, qb_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        a_addr = '0; a_cs = 1'b0; a_wn = 1'b1; a_rn = 1'b1; a_wd = '0; a_in = '0;
        b_addr = '0; b_cs = 1'b0; b_wn = 1'b1; b_rn = 1'b1; b_wd = '0; b_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("a_out_reset", a_out, 32'hDEAD_BEEF);
        check("a_oe_reset", a_oe, 32'h0);
        check("a_irq_reset", {31'b0, a_irq}, 32'h0);
        check("a_rd_reset", a_rd, 32'h0);
        check("b_out_reset", {24'b0, b_out}, 32'h3C);
        check("b_oe_reset", {24'b0, b_oe}, 32'h0);

        // Read data with all bits as outputs returns the reset value
        bus_wr(0, 3'd1, 32'hFFFF_FFFF);
        check("a_oe_dir", a_oe, 32'hFFFF_FFFF);
        bus_rd(0, 3'd0, 32'hDEAD_BEEF, "a_rd_data_reset");

        // data / outset / outclear
        bus_wr(0, 3'd0, 32'h0000_00F0);
        bus_wr(0, 3'd4, 32'h0000_000F);
        check("a_out_after_set", a_out, 32'h0000_00FF);
        bus_wr(0, 3'd5, 32'h0000_0030);
        check("a_out_after_clear", a_out, 32'h0000_00CF);
        bus_rd(0, 3'd0, 32'h0000_00CF, "a_rd_data_cf");
        bus_rd(0, 3'd4, 32'h0, "a_rd_outset");
        bus_rd(0, 3'd5, 32'h0, "a_rd_outclear");

        // Mixed direction read
        bus_wr(0, 3'd1, 32'h0000_FFFF);
        a_in = 32'hABCD_0000;
        bus_wr(0, 3'd0, 32'h0000_1234);
        repeat (4) @(negedge clk);
        bus_rd(0, 3'd0, 32'hABCD_1234, "a_rd_data_mixed");
        bus_rd(0, 3'd1, 32'h0000_FFFF, "a_rd_dir");
        bus_rd(0, 3'd3, 32'hABCD_0000, "a_rd_edgecap_pins");
        check("a_irq_masked", {31'b0, a_irq}, 32'h0);
        bus_wr(0, 3'd3, 32'hFFFF_FFFF);
        bus_rd(0, 3'd3, 32'h0, "a_rd_edgecap_cleared");

        // Bit3 rising edge: captured on the third edge after the pin change
        a_in = 32'hABCD_0008;
        repeat (2) @(negedge clk);
        bus_rd(0, 3'd3, 32'h0, "a_edgecap_before_lat");
        bus_rd(0, 3'd3, 32'h8, "a_edgecap_at_lat");
        check("a_irq_unmasked_off", {31'b0, a_irq}, 32'h0);
        bus_wr(0, 3'd2, 32'h8);
        check("a_irq_mask_cycle", {31'b0, a_irq}, 32'h0);
        @(negedge clk);
        check("a_irq_asserted", {31'b0, a_irq}, 32'h1);
        bus_wr(0, 3'd3, 32'h8);
        check("a_irq_clear_cycle", {31'b0, a_irq}, 32'h1);
        @(negedge clk);
        check("a_irq_cleared", {31'b0, a_irq}, 32'h0);
        bus_rd(0, 3'd2, 32'h8, "a_rd_irqmask");

        // Edge coinciding with a clear of the same bit: set wins
        a_in = 32'hABCD_0009;
        repeat (2) @(negedge clk);
        bus_wr(0, 3'd3, 32'h1);
        bus_rd(0, 3'd3, 32'h1, "a_edgecap_set_wins");
        check("a_irq_unmasked_bit0", {31'b0, a_irq}, 32'h0);
        bus_wr(0, 3'd3, 32'h1);
        bus_rd(0, 3'd3, 32'h0, "a_edgecap_w1c");

        // Falling edges are ignored in rising mode
        a_in = 32'hABCD_0000;
        repeat (4) @(negedge clk);
        bus_rd(0, 3'd3, 32'h0, "a_edgecap_no_fall");

        // 8-bit instance: upper bits masked, reserved offset inert
        bus_wr(1, 3'd1, 32'hFFFF_FFFF);
        bus_wr(1, 3'd0, 32'hFFFF_FFFF);
        bus_rd(1, 3'd0, 32'h0000_00FF, "b_rd_data_ff");
        check("b_out_ff", {24'b0, b_out}, 32'hFF);
        repeat (3) @(negedge clk);
        check("b_rd_hold", b_rd, 32'h0000_00FF);
        bus_wr(1, 3'd7, 32'h0);
        bus_rd(1, 3'd7, 32'h0, "b_rd_reserved7");
        bus_rd(1, 3'd6, 32'h0, "b_rd_reserved6");
        bus_rd(1, 3'd0, 32'h0000_00FF, "b_rd_data_after_res");
        bus_rd(1, 3'd1, 32'h0000_00FF, "b_rd_dir_after_res");
        check("b_out_after_res", {24'b0, b_out}, 32'hFF);
        check("b_irq_idle", {31'b0, b_irq}, 32'h0);

        repeat (3) @(negedge clk);
        check("a_queue_drained", qa_exp.size(), 32'h0);
        check("b_queue_drained", qb_exp.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qsys1_pio_ex.md
QSYS1_PIO_EX -- requirements
Module: qsys1_pio_ex

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the port width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the data_out value after reset (WIDTH bits).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, selecting the captured edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have parameter IRQ_EN, default 1; when 0, irq SHALL be tied 0 and irqmask SHALL read 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port address, input, 3 bits: register offset.
REQ-008 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-010 The block SHALL have port read_n, input, 1 bit: active-low read strobe.
REQ-011 The block SHALL have port writedata, input, 32 bits: write data.
REQ-012 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-013 The block SHALL have port in_port, input, WIDTH bits: asynchronous pin inputs.
REQ-014 The block SHALL have port out_port, output, WIDTH bits: driven pin values, equal to data_out.
REQ-015 The block SHALL have port oe, output, WIDTH bits: per-bit output enable, equal to direction.
REQ-016 The block SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-017 The register map SHALL be: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear; offsets 6-7 are reserved, read 0 and ignore writes.
REQ-018 A write SHALL occur when chipselect=1 and write_n=0, and SHALL use writedata[WIDTH-1:0].
REQ-019 A read SHALL occur when chipselect=1 and read_n=0; readdata SHALL be valid exactly 1 cycle later and hold until the next read; bits [31:WIDTH] SHALL read 0.
REQ-020 A data write SHALL load data_out; a data read SHALL return, per bit, in_sync when direction=0, else data_out.
REQ-021 An outset write SHALL perform data_out |= wd; an outclear write SHALL perform data_out &= ~wd; both SHALL read 0.
REQ-022 in_port SHALL pass through a 2-flop synchronizer (in_sync), followed by one delay flop (in_prev).
REQ-023 An edge SHALL be detected per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = in_sync ^ in_prev.
REQ-024 A detected edge SHALL set its edgecapture bit; an edgecapture write SHALL clear the bits where wd=1 (write-1-to-clear).
REQ-025 An edge and a clear on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-026 Edges SHALL be captured regardless of direction and irqmask.
REQ-027 irq SHALL be the registered value of |(edgecapture & irqmask), asserted 1 cycle after the contributing state.
REQ-028 Pin-to-edgecapture latency SHALL be 3 clk cycles (2 sync stages + capture).

Reset
REQ-029 While reset=1, the block SHALL set data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, readdata=0, irq=0.
REQ-030 While reset=1, the block SHALL load in_sync and in_prev with 0 and suppress edge detection in the first cycle after reset; an access in progress SHALL be discarded.

Structure
REQ-031 Package qsys1_pio_ex_pkg SHALL hold the register offset constants and the EDGE_TYPE encodings.
REQ-032 Sub-module qsys1_pio_ex_edge SHALL implement the synchronizer, the delay flop and the edge detector, parametrised by WIDTH and EDGE_TYPE.

Verification
REQ-033 Reset, then read data with direction=0xFFFFFFFF -> readdata=RESET_VALUE 1 cycle after the read; out_port=RESET_VALUE; oe=0 before the direction write.
REQ-034 Write data=0x0000_00F0, outset 0x0F, outclear 0x30 -> out_port=0x0000_00CF.
REQ-035 Direction=0x0000_FFFF, in_port=0xABCD_0000, data_out=0x1234 -> data read returns 0xABCD_1234.
REQ-036 EDGE_TYPE=0, in_port bit3 goes 0->1 -> edgecapture=0x8 3 cycles later; irqmask=0x8 -> irq=1 next cycle; write 0x8 to edgecapture -> irq=0 1 cycle after the clear.
REQ-037 A rising edge on bit0 coincides with an edgecapture write of 0x1 -> bit0 remains 1.
REQ-038 WIDTH=8: write 0xFFFF_FFFF to data -> readdata=0x0000_00FF; access to offset 7 -> readdata=0 and no register changes.
